// File: rtl/parity_check_buf.sv
// parity_check_buf: parity-checking flit buffer.
// Each incoming flit (payload in bits DATA_W:1, parity in bit 0) is checked
// against even (ODD=0) or odd (ODD=1) parity, tagged with an error bit and
// queued in a DEPTH-entry circular FIFO. Erroneous accepts are tallied in a
// saturating counter and a sticky flag, both cleared by clr_err.
//
// Optional build macro PARITY_DROP_EN: when defined, flits that fail the
// parity check are still accepted and counted, but are discarded instead of
// being buffered, and out_err is tied to 0.
//
// Handshake: on each side a transfer happens on a rising clk edge where
// valid=1 and ready=1 in the same cycle. A source holds valid and data stable
// until the transfer. in_ready depends only on buffer state (never on
// out_ready), and out_valid/out_data/out_err come from storage, so there is no
// combinational path from the input side to the output side.
module parity_check_buf #(
    parameter int DATA_W = 8,
    parameter int ODD    = 0,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W:0]   in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W:0]   out_data,
    output logic              out_err,
    output logic [CNT_W-1:0]  err_count,
    output logic              err_sticky,
    input  logic              clr_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);
    localparam logic             ODD_BIT  = (ODD != 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [DATA_W:0]  mem_data [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;
    logic             ready_en;
    logic             in_err;
    logic             accept;
    logic             do_write;
    logic             pop;
    logic             full;
    logic             empty;

    // Parity check on the raw input flit; 1 means the flit is corrupt.
    assign in_err = (^in_data[DATA_W:1]) ^ ODD_BIT ^ in_data[0];

    assign full      = (occ == FULL_OCC);
    assign empty     = (occ == '0);
    assign in_ready  = ready_en & ~full;
    assign out_valid = ~empty;
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

`ifdef PARITY_DROP_EN
    // Corrupt flits are consumed from upstream but never stored.
    assign do_write = accept & ~in_err;
    assign out_err  = 1'b0;
`else
    logic mem_err [DEPTH];

    assign do_write = accept;
    assign out_err  = mem_err[rd_ptr];

    // Error tag storage, written alongside the flit payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_err[i] <= 1'b0;
            end
        end else if (do_write) begin
            mem_err[wr_ptr] <= in_err;
        end
    end
`endif

    assign out_data = mem_data[rd_ptr];

    // Hold in_ready low until the first edge after reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    // Flit storage; cleared on reset so the head reads 0 while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
            end
        end else if (do_write) begin
            mem_data[wr_ptr] <= in_data;
        end
    end

    // Circular pointers (power-of-two depth wraps naturally) and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_write, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Saturating error counter and sticky flag; a new error beats a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count  <= '0;
            err_sticky <= 1'b0;
        end else if (accept && in_err) begin
            err_sticky <= 1'b1;
            if (clr_err) begin
                err_count <= CNT_W'(1);
            end else if (err_count != CNT_MAX) begin
                err_count <= err_count + CNT_W'(1);
            end
        end else if (clr_err) begin
            err_count  <= '0;
            err_sticky <= 1'b0;
        end
    end

endmodule
